// File: rtl/sum_loop_ctrl.sv
// Sequencer that drives a regfile/adder datapath to compute sum(1..N) with start/busy/done/err handshake.
// Optional iteration counter output enabled by defining SUM_LOOP_CTRL_ITER_CNT_EN.
`timescale 1ns/1ps

module sum_loop_ctrl #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] limit_in,
    input  logic          abort,
    input  logic          le,
    output logic          MuxSel,
    output logic [DW-1:0] imm,
    output logic [3:0]    raddr1,
    output logic [3:0]    raddr2,
    output logic [3:0]    waddr,
    output logic          wEn,
    output logic          outBuf,
    output logic          busy,
    output logic          done,
    output logic          err
`ifdef SUM_LOOP_CTRL_ITER_CNT_EN
    ,
    output logic [DW-1:0] iter_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_N,
        S_LD_ONE,
        S_INIT_I,
        S_CLR_SUM,
        S_CMP,
        S_ACC,
        S_INC,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_limit;
    logic [DW-1:0] r_imm;
    logic [3:0]    r_ra1;
    logic [3:0]    r_ra2;
    logic [3:0]    r_wa;
    logic          r_mux;
    logic          r_wen;
    logic          r_outbuf;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_accept;
    logic          w_reject;
    logic          w_abort;

    // N = all-ones is rejected: i could never exceed it.
    assign w_accept = (r_state == S_IDLE) && start && (limit_in != '1);
    assign w_reject = (r_state == S_IDLE) && start && (limit_in == '1);
    assign w_abort  = abort && (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_accept) w_next = S_LD_N;
                S_LD_N:    w_next = S_LD_ONE;
                S_LD_ONE:  w_next = S_INIT_I;
                S_INIT_I:  w_next = S_CLR_SUM;
                S_CLR_SUM: w_next = S_CMP;
                S_CMP:     w_next = le ? S_ACC : S_DONE;
                S_ACC:     w_next = S_INC;
                S_INC:     w_next = S_CMP;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_limit  <= '0;
            r_imm    <= '0;
            r_ra1    <= '0;
            r_ra2    <= '0;
            r_wa     <= '0;
            r_mux    <= 1'b0;
            r_wen    <= 1'b0;
            r_outbuf <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            if (w_accept) r_limit <= limit_in;
            r_imm    <= '0;
            r_ra1    <= '0;
            r_ra2    <= '0;
            r_wa     <= '0;
            r_mux    <= 1'b0;
            r_wen    <= 1'b0;
            r_outbuf <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= (w_next != S_IDLE);
            r_err    <= w_reject;
            case (w_next)
                S_LD_N:    begin r_mux <= 1'b1; r_wa <= 4'd3; r_wen <= 1'b1; end
                S_LD_ONE:  begin r_mux <= 1'b1; r_imm <= DW'(1); r_wa <= 4'd4; r_wen <= 1'b1; end
                S_INIT_I:  begin r_mux <= 1'b1; r_imm <= DW'(1); r_wa <= 4'd1; r_wen <= 1'b1; end
                S_CLR_SUM: begin r_mux <= 1'b1; r_wa <= 4'd2; r_wen <= 1'b1; end
                S_CMP:     begin r_ra1 <= 4'd1; r_ra2 <= 4'd3; end
                S_ACC:     begin r_ra1 <= 4'd2; r_ra2 <= 4'd1; r_wa <= 4'd2; r_wen <= 1'b1; end
                S_INC:     begin r_ra1 <= 4'd1; r_ra2 <= 4'd4; r_wa <= 4'd1; r_wen <= 1'b1; end
                S_DONE:    begin r_ra1 <= 4'd2; r_outbuf <= 1'b1; r_done <= 1'b1; end
                default:   ;
            endcase
        end
    end

    // Abort must suppress side effects in the very cycle it is seen, hence the combinational gating.
    assign wEn    = r_wen & ~w_abort;
    assign outBuf = r_outbuf & ~w_abort;
    assign done   = r_done & ~w_abort;
    assign imm    = (r_state == S_LD_N) ? r_limit : r_imm;
    assign MuxSel = r_mux;
    assign raddr1 = r_ra1;
    assign raddr2 = r_ra2;
    assign waddr  = r_wa;
    assign busy   = r_busy;
    assign err    = r_err;

`ifdef SUM_LOOP_CTRL_ITER_CNT_EN
    logic [DW-1:0] r_iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter <= '0;
        end else if (w_accept) begin
            r_iter <= '0;
        end else if (r_state == S_ACC && !w_abort) begin
            r_iter <= r_iter + DW'(1);
        end
    end

    assign iter_cnt = r_iter;
`endif

endmodule

// File: tb/tb_sum_loop_ctrl.sv
// Self-checking bench for sum_loop_ctrl: behavioural regfile datapath plus closed-form sum/timing reference.
`timescale 1ns/1ps

module tb_sum_loop_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] limit_in;
    logic       abort;
    logic       le;
    logic       MuxSel;
    logic [7:0] imm;
    logic [3:0] raddr1;
    logic [3:0] raddr2;
    logic [3:0] waddr;
    logic       wEn;
    logic       outBuf;
    logic       busy;
    logic       done;
    logic       err;
`ifdef SUM_LOOP_CTRL_ITER_CNT_EN
    logic [7:0] iter_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sum_loop_ctrl #(.DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .limit_in (limit_in),
        .abort    (abort),
        .le       (le),
        .MuxSel   (MuxSel),
        .imm      (imm),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .waddr    (waddr),
        .wEn      (wEn),
        .outBuf   (outBuf),
        .busy     (busy),
        .done     (done),
        .err      (err)
`ifdef SUM_LOOP_CTRL_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: regfile (R0 hardwired 0), adder, immediate mux, le comparator, output register.
    logic [7:0] rf [16];
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [7:0] outreg;

    always_comb begin
        rd1 = (raddr1 == 4'd0) ? 8'd0 : rf[raddr1];
        rd2 = (raddr2 == 4'd0) ? 8'd0 : rf[raddr2];
        le  = (rd1 <= rd2);
    end

    always @(posedge clk) begin
        if (wEn && waddr != 4'd0) rf[waddr] <= MuxSel ? imm : 8'(rd1 + rd2);
        if (outBuf) outreg <= rd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_sum(input int n);
        int s = 0;
        for (int i = 1; i <= n; i++) s += i;
        return s % 256;
    endfunction

    function automatic logic [31:0] out_vec();
        return {6'd0, busy, done, err, wEn, outBuf, MuxSel, imm, raddr1, raddr2, waddr};
    endfunction

    task automatic start_run(input logic [7:0] n, input logic with_abort);
        @(negedge clk);
        start    = 1'b1;
        limit_in = n;
        abort    = with_abort;
        @(posedge clk);
    endtask

    // Observes cycles t+1.. after acceptance; abort_k > 0 injects abort in cycle t+abort_k.
    task automatic watch_run(input int n, input int abort_k, input bit hold, input logic [7:0] new_limit);
        int end_k;
        int done_k = -1;
        int n_busy = 0;
        int n_done = 0;
        int n_ob   = 0;
        int n_acc  = 0;
        int n_err  = 0;
        bit aborting;
        aborting = (abort_k > 0);
        end_k = aborting ? abort_k + 1 : 7 + 3 * n;
        for (int k = 1; k <= end_k; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) start = 1'b0;
            if (k == 1) abort = 1'b0;
            if (hold && k == 6 + 3 * n) limit_in = new_limit;
            if (k == abort_k) abort = 1'b1;
            if (aborting && k == abort_k + 1) abort = 1'b0;
            #1;
            if (busy) n_busy++;
            if (done) begin n_done++; done_k = k; end
            if (outBuf) n_ob++;
            if (err) n_err++;
            if (wEn && waddr == 4'd2 && !MuxSel) n_acc++;
            if (k == abort_k) check("abort_wen", wEn, 0);
        end
        check("run_err", n_err, 0);
        if (aborting) begin
            check("abort_busy_cycles", n_busy, abort_k);
            check("abort_done", n_done, 0);
            check("abort_outbuf", n_ob, 0);
        end else begin
            check("done_cycle", done_k, 6 + 3 * n);
            check("done_count", n_done, 1);
            check("outbuf_count", n_ob, 1);
            check("busy_cycles", n_busy, 6 + 3 * n);
            check("acc_cycles", n_acc, n);
            check("sum", outreg, ref_sum(n));
`ifdef SUM_LOOP_CTRL_ITER_CNT_EN
            check("iter_cnt", iter_cnt, n);
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int ak;
        int n_err;
        int n_busy;
        int n_wen;

        rst = 1'b1;
        start = 1'b0;
        limit_in = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", out_vec(), 0);

        // N=10 then N=0
        start_run(8'd10, 1'b0);
        watch_run(10, -1, 1'b0, 8'd0);
        start_run(8'd0, 1'b0);
        watch_run(0, -1, 1'b0, 8'd0);

        // Rejected N=255, then N=3
        start_run(8'd255, 1'b0);
        n_err = 0; n_busy = 0; n_wen = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            #1;
            if (err) n_err++;
            if (busy) n_busy++;
            if (wEn) n_wen++;
        end
        check("reject_err", n_err, 1);
        check("reject_busy", n_busy, 0);
        check("reject_wen", n_wen, 0);
        start_run(8'd3, 1'b0);
        watch_run(3, -1, 1'b0, 8'd0);

        // Abort at t+20 on N=30, then N=4
        start_run(8'd30, 1'b0);
        watch_run(30, 20, 1'b0, 8'd0);
        start_run(8'd4, 1'b0);
        watch_run(4, -1, 1'b0, 8'd0);

        // start held through N=5; re-accepted in IDLE with a new limit
        start_run(8'd5, 1'b0);
        watch_run(5, -1, 1'b1, 8'd7);
        @(posedge clk);
        watch_run(7, -1, 1'b0, 8'd0);

        // start together with abort in IDLE is handled normally
        start_run(8'd6, 1'b1);
        watch_run(6, -1, 1'b0, 8'd0);

        // Reset in the first ACC cycle (t+6)
        start_run(8'd5, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        #1;
        check("pre_rst_acc_wen", wEn, 1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", out_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        start_run(8'd2, 1'b0);
        watch_run(2, -1, 1'b0, 8'd0);

        // Randomized runs
        repeat (6) begin
            n = $urandom_range(0, 60);
            start_run(8'(n), 1'($urandom_range(0, 1)));
            watch_run(n, -1, 1'b0, 8'd0);
        end
        n = $urandom_range(200, 254);
        start_run(8'(n), 1'b0);
        watch_run(n, -1, 1'b0, 8'd0);

        n = $urandom_range(3, 40);
        ak = $urandom_range(1, 6 + 3 * n);
        start_run(8'(n), 1'b0);
        watch_run(n, ak, 1'b0, 8'd0);
        n = $urandom_range(1, 40);
        start_run(8'(n), 1'b0);
        watch_run(n, -1, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sum_loop_ctrl.md
# sum_loop_ctrl

Sequencer for the dedicated register-file processor datapath (regfile + adder + immediate mux + `le` comparator + output buffer). It computes sum(1..N) for a host-supplied N by stepping the datapath through init, compare, accumulate and increment micro-steps. It adds a start/busy/done handshake, abort and error reporting, so the datapath can be reused for repeated runs without reset.

## Interface
- `DW`, 8, datapath word width; width of `limit_in` and `imm`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: run request, sampled only in IDLE.
- `limit_in` input DW: N, captured into a controller register when `start` is accepted.
- `abort` input 1: synchronous abort of the current run.
- `le` input 1: datapath flag, combinational `rdata1 <= rdata2`, unsigned.
- `MuxSel` output 1: write-data select; 1 = `imm`, 0 = adder (`rdata1 + rdata2`).
- `imm` output DW: immediate write data.
- `raddr1`, `raddr2` output 4: regfile read addresses.
- `waddr` output 4: regfile write address.
- `wEn` output 1: regfile write enable.
- `outBuf` output 1: one-cycle load enable of the datapath output register (loads `rdata1`).
- `busy` output 1: high from the cycle after start acceptance through DONE.
- `done` output 1: one-cycle pulse in DONE.
- `err` output 1: one-cycle pulse when `start` is rejected.

## Operation
- Register map: R0 = 0 (hardwired), R1 = i, R2 = sum, R3 = N, R4 = constant 1.
- Defaults in every state: all outputs 0. Unused addresses drive 0, never x.
- IDLE: if `start` and `limit_in != 2^DW-1`, capture `limit_in` and go to LD_N. If `start` and `limit_in == 2^DW-1`, pulse `err` for one cycle and stay in IDLE. This value is rejected because i would never exceed N.
- LD_N: `MuxSel=1`, `imm=N`, `waddr=3`, `wEn=1`.
- LD_ONE: `MuxSel=1`, `imm=1`, `waddr=4`, `wEn=1`.
- INIT_I: `MuxSel=1`, `imm=1`, `waddr=1`, `wEn=1`.
- CLR_SUM: `MuxSel=1`, `imm=0`, `waddr=2`, `wEn=1`.
- CMP: `raddr1=1`, `raddr2=3`, `wEn=0`. Go to ACC if `le`, otherwise go to DONE.
- ACC: `raddr1=2`, `raddr2=1`, `waddr=2`, `wEn=1` (sum += i).
- INC: `raddr1=1`, `raddr2=4`, `waddr=1`, `wEn=1` (i += 1), then go to CMP.
- DONE: `raddr1=2`, `outBuf=1`, `done=1`, then go to IDLE.
- Sum arithmetic wraps mod 2^DW. Wrap is a datapath property and raises no flag.
- `abort` is high in any non-IDLE state: next state is IDLE, `wEn` is forced to 0 in that cycle, and neither `done` nor `outBuf` is asserted. `abort` in IDLE is ignored.
- `start` while busy is ignored: no error and no recapture.
- `abort` and `start` together in IDLE: `start` is handled normally.

## Timing
- Reset: state = IDLE. All outputs are 0, and the captured N is 0.
- `start` accepted at cycle t:
  - LD_N at t+1, CLR_SUM at t+4, first CMP at t+5.
  - Each iteration takes 3 cycles (CMP, ACC, INC).
  - Final CMP at t+5+3N, DONE at t+6+3N, IDLE at t+7+3N.
- `busy` is high for cycles t+1 through t+6+3N.
- A new `start` is accepted at the earliest in the IDLE cycle t+7+3N.
- N=0: the first CMP sees 1<=0 false, so DONE occurs at t+6.
- Regfile writes commit at the clock edge ending the state, so a read in the next state sees the new value.
- `rst` mid-run: immediate return to IDLE with all outputs 0. Register-file contents are not touched by the controller.

## Configuration
- `SUM_LOOP_CTRL_ITER_CNT_EN` defined:
  - Adds output `iter_cnt` [DW-1:0].
  - Cleared to 0 on start acceptance and on reset.
  - Increments once per ACC cycle.
  - Holds its value after DONE or abort until the next accepted start.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then `start` with `limit_in=10`: `done` at t+36, output register = 55 (0x37), `busy` high for exactly 36 cycles, `iter_cnt=10` if enabled.
- `limit_in=0`: `done` at t+6, output = 0, no ACC cycle observed (`wEn` never high with `waddr=2` and `MuxSel=0`).
- `limit_in=255` (DW=8): `err` pulses 1 cycle, `busy` stays 0, no `wEn`. A following `start` with N=3 gives `done` at t+15 and output = 6.
- `limit_in=30`, `abort` at t+20: IDLE at t+21, no `done`, no `outBuf`. A restart with N=4 gives output = 10.
- `start` held high through a run with N=5: exactly one `done` at t+21. A second run begins at t+22 and re-captures `limit_in`.
- `rst` asserted mid-ACC: all outputs 0 asynchronously. After release, a run with N=2 completes with output = 3.
